// File: rtl/monopulse_ratio_divider.sv
// -----------------------------------------------------------------------------
// monopulse_ratio_divider
//
// Sequential signed fixed-point divider forming the monopulse ratio
//   o_ratio = error * 2^FRAC_BITS / reference
// with the quotient truncated toward zero and clamped symmetrically to
// +/-(2^(DATA_SIZE-1)-1). One quotient bit is produced per clock by a
// restoring divider working on magnitudes; the sign is applied at the end.
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset        synchronous active-low reset
//   i_valid        operand pair valid (upstream)
//   o_ready        operands accepted (high only while idle)
//   i_reference    signed divisor (sum channel)
//   i_error        signed dividend (difference channel)
//   o_valid        result valid, held until i_ready
//   i_ready        downstream accepts result
//   o_ratio        signed quotient with FRAC_BITS fractional bits
//   o_saturated    o_ratio was clamped
//   o_div_by_zero  i_reference was zero
// -----------------------------------------------------------------------------
module monopulse_ratio_divider #(
    parameter int DATA_SIZE = 64,
    parameter int FRAC_BITS = 16
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [DATA_SIZE-1:0] i_reference,
    input  logic signed [DATA_SIZE-1:0] i_error,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [DATA_SIZE-1:0] o_ratio,
    output logic                        o_saturated,
    output logic                        o_div_by_zero
);

    localparam int N     = DATA_SIZE;
    localparam int W     = DATA_SIZE + FRAC_BITS;
    localparam int CNT_W = $clog2(W);

    localparam logic [N-1:0] MAX_MAG = {1'b0, {(N-1){1'b1}}};
    localparam logic [W-1:0] MAX_Q   = {{(FRAC_BITS+1){1'b0}}, {(N-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    // Unsigned magnitude; the most negative value maps to 2^(N-1).
    function automatic logic [N-1:0] magnitude(input logic signed [N-1:0] x);
        logic [N-1:0] u;
        u = x;
        return x[N-1] ? -u : u;
    endfunction

    // Returns {saturated, clamped magnitude}.
    function automatic logic [N:0] clamp_quotient(input logic [W-1:0] q);
        if (q > MAX_Q)
            return {1'b1, MAX_MAG};
        else
            return {1'b0, q[N-1:0]};
    endfunction

    // Magnitude never exceeds MAX_MAG, so negation cannot overflow; -0 is +0.
    function automatic logic signed [N-1:0] apply_sign(input logic [N-1:0] mag,
                                                        input logic       neg);
        logic signed [N-1:0] s;
        s = mag;
        return neg ? -s : s;
    endfunction

    logic                accept;
    logic [W-1:0]        dividend;
    logic [N-1:0]        divisor;
    logic [N-1:0]        rem;
    logic [W-1:0]        quo;
    logic [CNT_W-1:0]    bit_cnt;
    logic                sign_neg;
    logic                err_neg;
    logic                err_zero;
    logic                dbz;

    logic [N:0]          trial;
    logic                take_bit;
    logic [N-1:0]        rem_next;
    logic                q_sat;
    logic [N-1:0]        q_mag;
    logic signed [N-1:0] res_ratio;
    logic                res_sat;

    assign o_ready = (state_q == IDLE);
    assign accept  = i_valid && o_ready;

    // Restoring step: trial remainder is always < 2*divisor, so the N-bit
    // difference is exact whenever the bit is taken.
    always_comb begin
        trial    = {rem, dividend[W-1]};
        take_bit = (trial >= {1'b0, divisor});
        rem_next = take_bit ? (trial[N-1:0] - divisor) : trial[N-1:0];
        {q_sat, q_mag} = clamp_quotient(quo);
        res_ratio = '0;
        res_sat   = 1'b0;
        if (dbz) begin
            if (!err_zero) begin
                res_ratio = apply_sign(MAX_MAG, err_neg);
                res_sat   = 1'b1;
            end
        end else begin
            res_ratio = apply_sign(q_mag, sign_neg);
            res_sat   = q_sat;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = (i_reference == '0) ? DONE : DIVIDE;
            end
            DIVIDE: begin
                if (bit_cnt == '0)
                    state_d = DONE;
            end
            DONE: begin
                if (o_valid && i_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- operand capture / iterative divide ----
    always_ff @(posedge i_clock) begin
        if (accept) begin
            dividend <= {magnitude(i_error), {FRAC_BITS{1'b0}}};
            divisor  <= magnitude(i_reference);
            rem      <= '0;
            quo      <= '0;
            bit_cnt  <= CNT_W'(W - 1);
            sign_neg <= i_error[N-1] ^ i_reference[N-1];
            err_neg  <= i_error[N-1];
            err_zero <= (i_error == '0);
            dbz      <= (i_reference == '0);
        end else if (state_q == DIVIDE) begin
            dividend <= {dividend[W-2:0], 1'b0};
            rem      <= rem_next;
            quo      <= {quo[W-2:0], take_bit};
            bit_cnt  <= bit_cnt - CNT_W'(1);
        end
    end

    // ---- result register: loaded on the first DONE cycle ----
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_valid       <= 1'b0;
            o_ratio       <= '0;
            o_saturated   <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else if (state_q == DONE && !o_valid) begin
            o_valid       <= 1'b1;
            o_ratio       <= res_ratio;
            o_saturated   <= res_sat;
            o_div_by_zero <= dbz;
        end else if (o_valid && i_ready) begin
            o_valid       <= 1'b0;
            o_ratio       <= '0;
            o_saturated   <= 1'b0;
            o_div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_monopulse_ratio_divider.sv
module tb_monopulse_ratio_divider;

    logic               i_clock;
    logic               i_reset;
    logic               i_valid;
    logic               o_ready;
    logic signed [15:0] i_reference;
    logic signed [15:0] i_error;
    logic               o_valid;
    logic               i_ready;
    logic signed [15:0] o_ratio;
    logic               o_saturated;
    logic               o_div_by_zero;

    int total = 0;
    int bad   = 0;

    monopulse_ratio_divider #(
        .DATA_SIZE(16),
        .FRAC_BITS(8)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_reference  (i_reference),
        .i_error      (i_error),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_ratio      (o_ratio),
        .o_saturated  (o_saturated),
        .o_div_by_zero(o_div_by_zero)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Reference: exact integer division of magnitudes, then clamp and sign.
    function automatic void model(input logic signed [15:0] e,
                                  input logic signed [15:0] r,
                                  output logic [15:0] ratio,
                                  output logic sat,
                                  output logic dz,
                                  output int lat);
        longint ae, ar, q;
        ae = longint'(e);
        ar = longint'(r);
        if (ae < 0) ae = -ae;
        if (ar < 0) ar = -ar;
        dz = (r == 0);
        if (dz) begin
            lat   = 1;
            sat   = (e != 0);
            ratio = (e == 0) ? 16'h0000 : (e > 0) ? 16'h7FFF : 16'h8001;
        end else begin
            lat = 25;
            q   = (ae * 256) / ar;
            sat = (q > 32767);
            if (sat) q = 32767;
            ratio = ((e < 0) != (r < 0)) ? 16'(-q) : 16'(q);
        end
    endfunction

    // Runs one transaction; lat = edges after the accept edge until o_valid.
    task automatic run_op(input logic [15:0] e, input logic [15:0] r,
                          output logic [15:0] ratio, output logic sat,
                          output logic dz, output int lat);
        int n;
        n = 0;
        while (!o_ready && n < 100) begin
            @(posedge i_clock); #1;
            n++;
        end
        i_error = e; i_reference = r; i_valid = 1'b1;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        i_error = 16'($urandom); i_reference = 16'($urandom);
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clock); #1;
            lat++;
        end
        if (!o_valid) lat = -1;
        ratio = o_ratio; sat = o_saturated; dz = o_div_by_zero;
        i_ready = 1'b1;
        @(posedge i_clock); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_valid = 1'b1; i_error = 16'sd5; i_reference = 16'sd2;
        repeat (3) @(posedge i_clock);
        #1;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        total++; if (o_ratio !== 16'h0000) begin bad++; $display("FAIL reset_ratio: got %h want 0000", o_ratio); end
        total++; if ({o_saturated, o_div_by_zero} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {o_saturated, o_div_by_zero}); end
        i_reset = 1'b1; i_valid = 1'b0;
        @(posedge i_clock); #1;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_nocapture: o_ready %b want 1", o_ready); end
    endtask

    task automatic test_vectors();
        logic [15:0] ev [9] = '{16'h0003, 16'hFFFD, 16'hFFFF, 16'h0001, 16'h0000, 16'h7FFF, 16'h8000, 16'h0005, 16'h0000};
        logic [15:0] rv [9] = '{16'h0004, 16'h0004, 16'h0003, 16'hFFFD, 16'hFFF9, 16'h0001, 16'h0001, 16'h0000, 16'h0000};
        logic [15:0] xr [9] = '{16'h00C0, 16'hFF40, 16'hFFAB, 16'hFFAB, 16'h0000, 16'h7FFF, 16'h8001, 16'h7FFF, 16'h0000};
        logic [8:0]  xs = 9'b0_1110_0000;
        logic [8:0]  xz = 9'b1_1000_0000;
        logic [15:0] ratio;
        logic        sat, dz;
        int          lat, xl;
        for (int i = 0; i < 9; i++) begin
            run_op(ev[i], rv[i], ratio, sat, dz, lat);
            xl = xz[i] ? 1 : 25;
            total++; if (ratio !== xr[i]) begin bad++; $display("FAIL vec%0d_ratio: got %h want %h", i, ratio, xr[i]); end
            total++; if (sat !== xs[i]) begin bad++; $display("FAIL vec%0d_sat: got %b want %b", i, sat, xs[i]); end
            total++; if (dz !== xz[i]) begin bad++; $display("FAIL vec%0d_dbz: got %b want %b", i, dz, xz[i]); end
            total++; if (lat != xl) begin bad++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, xl); end
        end
    endtask

    task automatic test_random();
        logic [15:0] e, r, ratio, xr;
        logic        sat, dz, xs, xd;
        int          lat, xl;
        for (int i = 0; i < 20; i++) begin
            e = 16'($urandom);
            r = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            if (i % 5 == 0) e = 16'($urandom_range(0, 300)) - 16'd150;
            model(e, r, xr, xs, xd, xl);
            run_op(e, r, ratio, sat, dz, lat);
            total++;
            if ({ratio, sat, dz} !== {xr, xs, xd} || lat != xl) begin
                bad++;
                $display("FAIL rand%0d e=%h r=%h: got ratio=%h sat=%b dbz=%b lat=%0d want ratio=%h sat=%b dbz=%b lat=%0d",
                         i, e, r, ratio, sat, dz, lat, xr, xs, xd, xl);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        i_error = 16'h7FFF; i_reference = 16'h0001; i_valid = 1'b1;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge i_clock); #1;
            n++;
        end
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout: o_valid %b want 1", o_valid); end
        for (int c = 0; c < 10; c++) begin
            i_valid = 1'b1; i_error = 16'($urandom); i_reference = 16'($urandom_range(1, 100));
            @(posedge i_clock); #1;
            total++;
            if ({o_valid, o_ready, o_ratio, o_saturated, o_div_by_zero} !== {1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold%0d: got v=%b rdy=%b ratio=%h sat=%b dbz=%b want v=1 rdy=0 ratio=7fff sat=1 dbz=0",
                         c, o_valid, o_ready, o_ratio, o_saturated, o_div_by_zero);
            end
        end
        i_valid = 1'b0; i_ready = 1'b1;
        @(posedge i_clock); #1;
        i_ready = 1'b0;
        total++; if ({o_ready, o_valid} !== 2'b10) begin bad++; $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", o_ready, o_valid); end
        total++; if (o_saturated !== 1'b0) begin bad++; $display("FAIL bp_flag_clear: got sat=%b want 0", o_saturated); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ev [6], rv [6];
        logic [17:0] expq [$];
        logic [17:0] want;
        logic [15:0] xr;
        logic        xs, xd, will_accept, will_out;
        int          xl, sent, got, cyc;
        for (int i = 0; i < 6; i++) begin
            ev[i] = 16'($urandom);
            rv[i] = (i == 2) ? 16'h0000 : 16'($urandom_range(1, 2000)) - 16'd1000;
        end
        sent = 0; got = 0; cyc = 0;
        i_ready = 1'b1;
        while (got < 6 && cyc < 1000) begin
            if (sent < 6) begin
                i_valid = 1'b1; i_error = ev[sent]; i_reference = rv[sent];
            end else begin
                i_valid = 1'b0;
            end
            will_accept = i_valid && o_ready;
            will_out    = o_valid && i_ready;
            if (will_out) begin
                want = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
                total++;
                if ({o_div_by_zero, o_saturated, o_ratio} !== want) begin
                    bad++;
                    $display("FAIL b2b%0d: got dbz=%b sat=%b ratio=%h want dbz=%b sat=%b ratio=%h",
                             got, o_div_by_zero, o_saturated, o_ratio, want[17], want[16], want[15:0]);
                end
                got++;
            end
            @(posedge i_clock); #1;
            cyc++;
            if (will_accept) begin
                model(ev[sent], rv[sent], xr, xs, xd, xl);
                expq.push_back({xd, xs, xr});
                sent++;
            end
        end
        i_valid = 1'b0; i_ready = 1'b0;
        total++; if (got != 6) begin bad++; $display("FAIL b2b_count: got %0d results want 6", got); end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] ratio;
        logic        sat, dz, seen;
        int          lat;
        i_error = 16'sd3; i_reference = 16'sd4; i_valid = 1'b1;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        @(posedge i_clock); #1;
        i_reset = 1'b1;
        total++;
        if ({o_valid, o_ready, o_ratio} !== {1'b0, 1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL midreset_state: got v=%b rdy=%b ratio=%h want v=0 rdy=1 ratio=0000", o_valid, o_ready, o_ratio);
        end
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge i_clock); #1;
            if (o_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_discard: stale o_valid seen=%b want 0", seen); end
        run_op(16'sd5, 16'sd2, ratio, sat, dz, lat);
        total++;
        if ({ratio, sat, dz} !== {16'h0280, 1'b0, 1'b0} || lat != 25) begin
            bad++;
            $display("FAIL midreset_fresh: got ratio=%h sat=%b dbz=%b lat=%0d want ratio=0280 sat=0 dbz=0 lat=25", ratio, sat, dz, lat);
        end
    endtask

    initial begin
        i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_error = '0; i_reference = '0;
        @(posedge i_clock); #1;
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
